// File: rtl/msx_mouse_reader.sv
// rtl/msx_mouse_reader.sv - host-side MSX mouse reader
// Walks the strobe line through four nibble phases and presents signed X/Y deltas plus buttons.
module msx_mouse_reader #(
  parameter int RESET_CYC = 6144,
  parameter int PHASE_CYC = 2048,
  parameter int SYNC_STG  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] data_in,
  output logic       strobe,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid,
  output logic       busy
);

  localparam logic [15:0] RESET_LAST = 16'(RESET_CYC - 1);
  localparam logic [15:0] PHASE_LAST = 16'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTL = 3'd1,
    S_PH0  = 3'd2,
    S_PH1  = 3'd3,
    S_PH2  = 3'd4,
    S_PH3  = 3'd5,
    S_PH4  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;
  logic        strobe_d;
  logic        rst_last;
  logic        ph_last;
  logic [1:0]  rst_sync;
  logic        rst_n_i;
  logic [5:0]  sync_q [SYNC_STG];
  logic [5:0]  d_sync;
  logic [3:0]  nib0;
  logic [3:0]  nib1;
  logic [3:0]  nib2;
  logic [3:0]  nib3;
  logic [1:0]  btn_r;

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_i = rst_sync[1];

  // Idle value is buttons released, no motion.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STG; i++) begin
        sync_q[i] <= 6'b110000;
      end
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < SYNC_STG; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign d_sync   = sync_q[SYNC_STG-1];
  assign rst_last = (cnt == RESET_LAST);
  assign ph_last  = (cnt == PHASE_LAST);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= S_IDLE;
      strobe <= 1'b0;
      cnt    <= 16'd0;
    end else begin
      state  <= next_state;
      strobe <= strobe_d;
      if (next_state != state) begin
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)    next_state = S_RSTL;
      S_RSTL:  if (rst_last) next_state = S_PH0;
      S_PH0:   if (ph_last)  next_state = S_PH1;
      S_PH1:   if (ph_last)  next_state = S_PH2;
      S_PH2:   if (ph_last)  next_state = S_PH3;
      S_PH3:   if (ph_last)  next_state = S_PH4;
      S_PH4:   if (ph_last)  next_state = S_DONE;
      S_DONE:                next_state = S_IDLE;
      default:               next_state = S_IDLE;
    endcase
  end

  // Strobe follows the state being entered so it toggles on the entry edge.
  always_comb begin
    strobe_d = 1'b0;
    case (next_state)
      S_PH0, S_PH2, S_PH4: strobe_d = 1'b1;
      default:             strobe_d = 1'b0;
    endcase
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nib0  <= 4'd0;
      nib1  <= 4'd0;
      nib2  <= 4'd0;
      nib3  <= 4'd0;
      btn_r <= 2'd0;
      dx    <= 8'd0;
      dy    <= 8'd0;
      btn   <= 2'd0;
      valid <= 1'b0;
    end else begin
      valid <= (state == S_DONE);
      if (state == S_PH0 && ph_last) nib0 <= d_sync[3:0];
      if (state == S_PH1 && ph_last) nib1 <= d_sync[3:0];
      if (state == S_PH2 && ph_last) nib2 <= d_sync[3:0];
      if (state == S_PH3 && ph_last) begin
        nib3  <= d_sync[3:0];
        btn_r <= ~d_sync[5:4];
      end
      if (state == S_DONE) begin
        dx  <= {nib0, nib1};
        dy  <= {nib2, nib3};
        btn <= btn_r;
      end
    end
  end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// tb/tb_msx_mouse_reader.sv - randomized self-checking bench for msx_mouse_reader
module tb_msx_mouse_reader;

  localparam int R_D   = 6144;
  localparam int P_D   = 2048;
  localparam int R_S   = 24;
  localparam int P_S   = 8;
  localparam int LAT_D = R_D + 5*P_D + 1;
  localparam int LAT_S = R_S + 5*P_S + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst_n = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       d_start = 1'b0;
  logic       s_start = 1'b0;
  logic [5:0] d_data;
  logic [5:0] s_data;
  logic       d_strobe, s_strobe, d_valid, s_valid, d_busy, s_busy;
  logic [7:0] d_dx, d_dy, s_dx, s_dy;
  logic [1:0] d_btn, s_btn;

  msx_mouse_reader u_big (
    .clk(clk), .reset_n(d_rst_n), .start(d_start), .data_in(d_data), .strobe(d_strobe),
    .dx(d_dx), .dy(d_dy), .btn(d_btn), .valid(d_valid), .busy(d_busy)
  );

  msx_mouse_reader #(.RESET_CYC(R_S), .PHASE_CYC(P_S), .SYNC_STG(2)) u_small (
    .clk(clk), .reset_n(s_rst_n), .start(s_start), .data_in(s_data), .strobe(s_strobe),
    .dx(s_dx), .dy(s_dy), .btn(s_btn), .valid(s_valid), .busy(s_busy)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Index 0 models the mouse on the small instance, index 1 on the default one.
  logic [3:0] dev_nib [2][4];
  logic [1:0] dev_raw [2];
  bit         dev_ovr [2];
  logic [5:0] dev_ovr_val [2];
  int         dev_edges [2];
  int         dev_low [2];
  logic       dev_prev [2];
  logic       stb_now;
  logic [3:0] nib_now [2];

  // Mouse: the n-th strobe transition presents nibble n-1; a long low returns it to idle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      stb_now = (i == 1) ? d_strobe : s_strobe;
      if (stb_now !== dev_prev[i]) begin
        dev_edges[i]++;
        dev_low[i] = 0;
      end else if (stb_now === 1'b0) begin
        dev_low[i]++;
      end
      if (dev_low[i] >= ((i == 1) ? R_D : R_S) / 2) dev_edges[i] = 0;
      dev_prev[i] = stb_now;
      nib_now[i] = (dev_edges[i] >= 1 && dev_edges[i] <= 4) ? dev_nib[i][dev_edges[i]-1] : 4'h0;
    end
    s_data = dev_ovr[0] ? dev_ovr_val[0] : {dev_raw[0], nib_now[0]};
    d_data = dev_ovr[1] ? dev_ovr_val[1] : {dev_raw[1], nib_now[1]};
  end

  task automatic txn(input bit big, input string tag, input logic [7:0] exp_dx,
                     input logic [7:0] exp_dy, input logic [1:0] exp_btn, input bit noise,
                     input int chg_at, input logic [5:0] chg_val);
    int   lat;
    int   rc;
    int   pc;
    int   seen;
    int   edges[$];
    logic prev_stb;
    lat  = big ? LAT_D : LAT_S;
    rc   = big ? R_D : R_S;
    pc   = big ? P_D : P_S;
    seen = -1;
    @(negedge clk);
    if (big) d_start = 1'b1; else s_start = 1'b1;
    @(posedge clk);
    #1;
    if (big) d_start = 1'b0; else s_start = 1'b0;
    check({tag, " busy_start"}, big ? d_busy : s_busy, 1);
    prev_stb = big ? d_strobe : s_strobe;
    check({tag, " strobe_rstl"}, prev_stb, 0);
    for (int k = 1; k <= lat + 20; k++) begin
      @(posedge clk);
      #1;
      if ((big ? d_strobe : s_strobe) !== prev_stb) begin
        edges.push_back(k);
        prev_stb = big ? d_strobe : s_strobe;
      end
      if (!big && noise) s_start = (k < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ((big ? d_valid : s_valid) === 1'b1) begin
        seen = k;
        break;
      end
      if (k == chg_at) begin
        dev_ovr_val[big ? 1 : 0] = chg_val;
        if (big) d_data = chg_val; else s_data = chg_val;
      end
    end
    check({tag, " latency"}, seen, lat);
    check({tag, " dx"}, big ? d_dx : s_dx, exp_dx);
    check({tag, " dy"}, big ? d_dy : s_dy, exp_dy);
    check({tag, " btn"}, big ? d_btn : s_btn, exp_btn);
    check({tag, " strobe_edges"}, edges.size(), 6);
    for (int i = 0; i < edges.size() && i < 6; i++) begin
      check({tag, " strobe_edge_time"}, edges[i], rc + i*pc);
    end
    @(posedge clk);
    #1;
    check({tag, " valid_one_cycle"}, big ? d_valid : s_valid, 0);
    check({tag, " busy_idle"}, big ? d_busy : s_busy, 0);
  endtask

  logic [3:0] n [4];
  logic [1:0] raw;
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  bit         saw_valid;
  int         vk [3];
  int         nv;

  initial begin
    for (int i = 0; i < 2; i++) begin
      dev_raw[i]     = 2'b11;
      dev_ovr[i]     = 1'b0;
      dev_ovr_val[i] = 6'b110000;
      dev_edges[i]   = 0;
      dev_low[i]     = 0;
      dev_prev[i]    = 1'b0;
      for (int j = 0; j < 4; j++) dev_nib[i][j] = 4'h0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset strobe", {d_strobe, s_strobe}, 0);
    check("reset dx", {d_dx, s_dx}, 0);
    check("reset dy", {d_dy, s_dy}, 0);
    check("reset btn_valid_busy", {d_btn, s_btn, d_valid, s_valid, d_busy, s_busy}, 0);
    @(negedge clk);
    d_rst_n = 1'b1;
    s_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset busy", {d_busy, s_busy}, 0);

    dev_nib[1] = '{4'h3, 4'hC, 4'hF, 4'hE};
    dev_raw[1] = 2'b10;
    txn(1'b1, "default", 8'h3C, 8'hFE, 2'b01, 1'b0, -1, 6'd0);

    dev_nib[0] = '{4'h9, 4'h1, 4'h7, 4'h2};
    dev_raw[0] = 2'b01;
    txn(1'b0, "pre_reset", 8'h91, 8'h72, 2'b10, 1'b0, -1, 6'd0);

    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    repeat (R_S + 2*P_S + 2) @(posedge clk);
    #1;
    check("mid_ph2 strobe", s_strobe, 1);
    @(negedge clk);
    s_rst_n = 1'b0;
    #1;
    check("mid_reset strobe", s_strobe, 0);
    check("mid_reset outputs", {s_dx, s_dy, s_btn, s_valid, s_busy}, 0);
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (s_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("mid_reset no_valid", saw_valid, 0);
    @(negedge clk);
    s_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    txn(1'b0, "after_reset", 8'h91, 8'h72, 2'b10, 1'b0, -1, 6'd0);

    for (int t = 0; t < 12; t++) begin
      for (int j = 0; j < 4; j++) n[j] = 4'($urandom_range(0, 15));
      raw = 2'($urandom_range(0, 3));
      dev_nib[0] = n;
      dev_raw[0] = raw;
      txn(1'b0, "random", 8'(n[0] * 16 + n[1]), 8'(n[2] * 16 + n[3]), ~raw, 1'(t % 2), -1, 6'd0);
    end

    dev_ovr[0]     = 1'b1;
    dev_ovr_val[0] = 6'b110000;
    txn(1'b0, "all_zero", 8'h00, 8'h00, 2'b00, 1'b0, -1, 6'd0);

    a_nib = 4'h5;
    b_nib = 4'hA;
    for (int kc = 1; kc <= 3; kc += 2) begin
      dev_ovr_val[0] = {2'b11, a_nib};
      repeat (2) @(posedge clk);
      txn(1'b0, (kc == 1) ? "sync_late" : "sync_early",
          {(kc >= 2) ? b_nib : a_nib, b_nib}, {b_nib, b_nib}, 2'b00, 1'b0,
          R_S + P_S - kc - 1, {2'b11, b_nib});
    end
    dev_ovr[0] = 1'b0;

    for (int j = 0; j < 4; j++) n[j] = 4'($urandom_range(0, 15));
    dev_nib[0] = n;
    dev_raw[0] = 2'b00;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    nv = 0;
    for (int k = 1; k <= 3*(LAT_S + 1) + 10 && nv < 3; k++) begin
      @(posedge clk);
      #1;
      if (s_valid === 1'b1) begin
        vk[nv] = k;
        nv++;
        if (nv == 3) s_start = 1'b0;
        check("b2b dxdy", {s_dx, s_dy, s_btn}, {n[0], n[1], n[2], n[3], 2'b11});
      end
    end
    s_start = 1'b0;
    check("b2b count", nv, 3);
    for (int i = 0; i < nv; i++) check("b2b spacing", vk[i], LAT_S + i*(LAT_S + 1));
    repeat (2) @(posedge clk);
    #1;
    check("b2b idle", s_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
